mips_mem_arbiter: RTL

MIPS_MEM_ARBITER -- requirements
Module: mips_mem_arbiter

---
 rtl/mips_pkg.sv | 37 +++
 rtl/mips_mem_arbiter_if.sv | 39 +++
 rtl/mips_starve_ctr.sv | 29 ++
 rtl/mips_mem_arbiter.sv | 99 +++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS constants, instruction-type codes and arbiter FSM encoding
// Purpose : common definitions imported by the memory arbiter and its helpers.
// Contents: opcode constants, instruction-type enum with a decode helper,
//           read-return FSM state encoding (IDLE / RD_IF / RD_DM).
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_HLT   = 6'h3F;

  typedef enum logic [1:0] {
    ITYPE_R = 2'd0,
    ITYPE_I = 2'd1,
    ITYPE_J = 2'd2,
    ITYPE_H = 2'd3
  } instr_type_e;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_RD_IF = 2'd1,
    ARB_RD_DM = 2'd2
  } arb_state_e;

  function automatic instr_type_e decode_type(input logic [5:0] op);
    case (op)
      OP_RTYPE: decode_type = ITYPE_R;
      OP_J:     decode_type = ITYPE_J;
      OP_HLT:   decode_type = ITYPE_H;
      default:  decode_type = ITYPE_I;
    endcase
  endfunction

endpackage

// File: rtl/mips_mem_arbiter_if.sv
// rtl/mips_mem_arbiter_if.sv - bundle of requester and memory signals around the arbiter
// Purpose : groups the IF requester, DM requester, halt and memory-side signals.
// Modports: slave  - the arbiter (takes requests and mem_rdata, drives grants/returns/memory)
//           master - the environment (requesters plus memory)
interface mips_mem_arbiter_if #(
  parameter int AW = 10,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_gnt;
  logic          dm_rvalid;
  logic [DW-1:0] dm_rdata;
  logic          halt;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, halt, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, halt, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mips_starve_ctr.sv
// rtl/mips_starve_ctr.sv - saturating starvation counter for the fetch requester
// Purpose: counts consecutive denied fetch cycles, saturating at MAX.
// Ports  : clk, rst (async active-high), inc (count one), clr (zero, wins over inc),
//          at_max (count has reached MAX).
module mips_starve_ctr #(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_max
);
  localparam int W = $clog2(MAX + 1);

  logic [W-1:0] cnt_q;

  assign at_max = (cnt_q == W'(MAX));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && !at_max) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
endmodule

// File: rtl/mips_mem_arbiter.sv
// rtl/mips_mem_arbiter.sv - single-port unified memory arbiter for instruction fetch and data
// Purpose: shares one synchronous single-port memory between IF and DM, one access per
//          cycle, grants combinational, read data returned one cycle after the grant.
// Ports  : clk, rst (async active-high), bus (mips_mem_arbiter_if.slave: if_*, dm_*,
//          halt, mem_*).
// Config : MIPS_MEM_ARB_STARVE_GUARD_EN - when defined, IF is forced after STARVE_MAX
//          consecutive denied cycles; otherwise DM always wins.
module mips_mem_arbiter
  import mips_pkg::*;
#(
  parameter int AW         = 10,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  mips_mem_arbiter_if.slave bus
);

  if (STARVE_MAX < 1) begin : g_bad_starve_max
    $error("STARVE_MAX must be at least 1");
  end

  arb_state_e    state_q;
  logic          halted_q;
  logic          if_ok;
  logic          dm_ok;
  logic          if_gnt;
  logic          dm_gnt;
  logic [AW-1:0] mem_addr_d;
  logic [DW-1:0] mem_wdata_d;

  // Grants are masked during reset so nothing reaches the memory while rst is high.
  assign if_ok = bus.if_req & ~halted_q & ~rst;
  assign dm_ok = bus.dm_req & ~rst;

`ifdef MIPS_MEM_ARB_STARVE_GUARD_EN
  logic starve_inc;
  logic starve_clr;
  logic starve_at_max;

  assign if_gnt     = if_ok & (~dm_ok | starve_at_max);
  assign starve_inc = bus.if_req & ~if_gnt;
  assign starve_clr = ~starve_inc;

  mips_starve_ctr #(.MAX(STARVE_MAX)) u_starve_ctr (
    .clk    (clk),
    .rst    (rst),
    .inc    (starve_inc),
    .clr    (starve_clr),
    .at_max (starve_at_max)
  );
`else
  assign if_gnt = if_ok & ~dm_ok;
`endif

  assign dm_gnt = dm_ok & ~if_gnt;

  always_comb begin
    mem_addr_d = '0;
    if (dm_gnt) begin
      mem_addr_d = bus.dm_addr;
    end else if (if_gnt) begin
      mem_addr_d = bus.if_addr;
    end
  end

  assign mem_wdata_d = (dm_gnt && bus.dm_we) ? bus.dm_wdata : '0;

  assign bus.if_gnt    = if_gnt;
  assign bus.dm_gnt    = dm_gnt;
  assign bus.mem_en    = if_gnt | dm_gnt;
  assign bus.mem_we    = dm_gnt & bus.dm_we;
  assign bus.mem_addr  = mem_addr_d;
  assign bus.mem_wdata = mem_wdata_d;

  // The state records which requester owns the data the memory presents this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ARB_IDLE;
      halted_q <= 1'b0;
    end else begin
      halted_q <= halted_q | bus.halt;
      if (if_gnt) begin
        state_q <= ARB_RD_IF;
      end else if (dm_gnt && !bus.dm_we) begin
        state_q <= ARB_RD_DM;
      end else begin
        state_q <= ARB_IDLE;
      end
    end
  end

  assign bus.if_rvalid = (state_q == ARB_RD_IF);
  assign bus.dm_rvalid = (state_q == ARB_RD_DM);
  assign bus.if_rdata  = (state_q == ARB_RD_IF) ? bus.mem_rdata : '0;
  assign bus.dm_rdata  = (state_q == ARB_RD_DM) ? bus.mem_rdata : '0;

endmodule
